// File: rtl/ahb_dma_pkg.sv
// Shared types and constants for the AHB DMA peripheral responder.
package ahb_dma_pkg;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    SZ_BYTE = 3'b000,
    SZ_HALF = 3'b001,
    SZ_WORD = 3'b010
  } hsize_e;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slv_state_e;

  // Byte offsets of the descriptor words inside the 16-byte window.
  localparam logic [3:0] DESC_SRC  = 4'd0;
  localparam logic [3:0] DESC_DST  = 4'd4;
  localparam logic [3:0] DESC_SIZE = 4'd8;
  localparam logic [3:0] DESC_CTRL = 4'd12;

  // Halfwords must sit on even addresses, words on multiples of four.
  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] lsb);
    return ((size == SZ_HALF) && lsb[0]) || ((size == SZ_WORD) && (lsb != 2'b00));
  endfunction

endpackage

// File: rtl/dma_req_handshake.sv
// DmacReq/ReqAck flop: start sets, ack clears, start wins when both arrive together.
module dma_req_handshake (
  input  logic clk,
  input  logic rst,
  input  logic req_start,
  input  logic req_ack,
  output logic dma_req
);

  logic dma_req_q, dma_req_d;

  // Next request level; ack only has an effect while a request is up.
  always_comb begin
    dma_req_d = dma_req_q;
    if (req_ack)   dma_req_d = 1'b0;
    if (req_start) dma_req_d = 1'b1;
  end

  // Request register.
  always_ff @(posedge clk) begin
    if (rst) dma_req_q <= 1'b0;
    else     dma_req_q <= dma_req_d;
  end

  assign dma_req = dma_req_q;

endmodule

// File: rtl/ahb_dma_periph_slave.sv
// AHB-Lite responder modelling a DMA-capable peripheral: byte-lane local memory
// (descriptor window at CFG_BASE is plain memory), programmable wait states and
// the DmacReq/ReqAck request line.
// Build option: define AHB_SLV_ERR_EN to answer out-of-range/misaligned
// transfers with the two-cycle ERROR response instead of a silent OKAY.
module ahb_dma_periph_slave
  import ahb_dma_pkg::*;
#(
  parameter int         MEM_DEPTH   = 256,
  parameter logic [7:0] CFG_BASE    = 8'hA0,
  parameter int         WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADYIN,
  input  logic [31:0] HWDATA,
  input  logic [3:0]  WSTRB,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  input  logic        req_start,
  output logic        dma_req,
  input  logic        req_ack,
  output logic        busy
);

  localparam int         AW      = $clog2(MEM_DEPTH);
  localparam int         WORDS   = MEM_DEPTH / 4;
  localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  if (MEM_DEPTH < 16 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0 || WAIT_STATES < 0 ||
      WAIT_STATES > 15 || CFG_BASE[1:0] != 2'b00 || int'(CFG_BASE) + 16 > MEM_DEPTH)
  begin : g_param_check
    $error("ahb_dma_periph_slave: illegal MEM_DEPTH/CFG_BASE/WAIT_STATES");
  end

  slv_state_e       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [AW-1:2]    addr_q, addr_d;
  logic             write_q, write_d;
  logic             oor_q, oor_d;
  logic [31:0]      hrdata_q, hrdata_d;

  logic             accept, bus_oor, wr_en, rd_read, rd_oor, rd_load;
  logic [AW-1:2]    wr_word, rd_word;
  logic [3:0][7:0]  lane_rd;

  // A new address phase is only taken in states that drive HREADYOUT high.
  assign accept = ((state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2)) &&
                  HSEL && HREADYIN && ((HTRANS == TR_NONSEQ) || (HTRANS == TR_SEQ));
  assign bus_oor = (HADDR[31:AW] != '0) || misaligned(HSIZE, HADDR[1:0]);

  // Write commits in the DATA cycle; reset in that cycle drops it.
  assign wr_en   = !rst && (state_q == ST_DATA) && write_q && !oor_q;
  assign wr_word = addr_q;

  // Read data is fetched on the edge that enters DATA: from the latched address
  // when leaving WAIT, otherwise straight from the bus address phase.
  assign rd_word = (state_q == ST_WAIT) ? addr_q  : HADDR[AW-1:2];
  assign rd_read = (state_q == ST_WAIT) ? !write_q : !HWRITE;
  assign rd_oor  = (state_q == ST_WAIT) ? oor_q   : bus_oor;

  // Next-state logic and address-phase capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    oor_d   = oor_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          addr_d  = HADDR[AW-1:2];
          write_d = HWRITE;
          oor_d   = bus_oor;
          cnt_d   = WS_INIT;
          state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;
`ifdef AHB_SLV_ERR_EN
          if (bus_oor) state_d = ST_ERR1;
`endif
        end
      end
    endcase
  end

  assign rd_load = (state_d == ST_DATA) && rd_read;

  // Read-data register; a write to the same word in this very cycle is forwarded.
  always_comb begin
    hrdata_d = hrdata_q;
    if (rd_load) begin
      for (int c = 0; c < 4; c++) begin
        if (rd_oor)
          hrdata_d[8*c +: 8] = 8'h00;
        else if (wr_en && WSTRB[c] && (wr_word == rd_word))
          hrdata_d[8*c +: 8] = HWDATA[8*c +: 8];
        else
          hrdata_d[8*c +: 8] = lane_rd[c];
      end
    end
  end

  // State, counter, captured address phase and read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      oor_q    <= 1'b0;
      hrdata_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      oor_q    <= oor_d;
      hrdata_q <= hrdata_d;
    end
  end

  // One byte-wide memory per lane so WSTRB maps directly onto lane write enables.
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [WORDS];

    // Lane write port.
    always_ff @(posedge clk) begin
      if (wr_en && WSTRB[gi]) lane_mem[wr_word] <= HWDATA[8*gi +: 8];
    end

    assign lane_rd[gi] = lane_mem[rd_word];
  end

  dma_req_handshake u_req (
    .clk       (clk),
    .rst       (rst),
    .req_start (req_start),
    .req_ack   (req_ack),
    .dma_req   (dma_req)
  );

  assign HRDATA    = hrdata_q;
  assign HREADYOUT = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
  assign HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ahb_dma_periph_slave.sv
// Bench for ahb_dma_periph_slave: three instances (0, 2 and 3 wait states) run the
// same pipelined transfer table against a scoreboard, followed by hand-written
// handshake and reset-during-WAIT sequences. Honours AHB_SLV_ERR_EN if defined.
module tb_ahb_dma_periph_slave;
  import ahb_dma_pkg::*;

`ifdef AHB_SLV_ERR_EN
  localparam bit ERR_MODE = 1'b1;
`else
  localparam bit ERR_MODE = 1'b0;
`endif

  typedef struct {
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int          idx;
    int          low;
    logic [1:0]  resp;
    logic        chk_rd;
    logic [31:0] rd;
  } exp_t;

  logic        clk, rst;
  logic [2:0]  hsel;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  wstrb;
  logic        req_start, req_ack;
  logic [2:0]  hready, busy, dma_req;
  logic [31:0] hrdata [3];
  logic [1:0]  hresp [3];

  int n_checks = 0;
  int n_fail   = 0;
  vec_t tab[$];
  exp_t sb[$];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    ahb_dma_periph_slave #(
      .MEM_DEPTH   (256),
      .CFG_BASE    (8'hA0),
      .WAIT_STATES ((gi == 0) ? 0 : gi + 1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .HSEL      (hsel[gi]),
      .HADDR     (haddr),
      .HTRANS    (htrans),
      .HWRITE    (hwrite),
      .HSIZE     (hsize),
      .HREADYIN  (hready[gi]),
      .HWDATA    (hwdata),
      .WSTRB     (wstrb),
      .HRDATA    (hrdata[gi]),
      .HREADYOUT (hready[gi]),
      .HRESP     (hresp[gi]),
      .req_start (req_start),
      .dma_req   (dma_req[gi]),
      .req_ack   (req_ack),
      .busy      (busy[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : d + 1;
  endfunction

  function automatic logic is_oor(input logic [31:0] a, input logic [2:0] sz);
    return (a[31:8] != 24'h0) || (sz == 3'b001 && a[0]) || (sz == 3'b010 && a[1:0] != 2'b00);
  endfunction

  function automatic void add(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                              input logic [2:0] sz, input logic [31:0] wd,
                              input logic [3:0] st, input logic [31:0] ex);
    vec_t v;
    v.trans = tr; v.wr = wr; v.addr = a; v.size = sz; v.wdata = wd; v.strb = st; v.exp = ex;
    tab.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pipelined AHB master over tab[] toward instance d; entered and left at posedge+1.
  task automatic run_table(input int d);
    int   nxt = 0;
    int   cur = -1;
    int   low = 0;
    int   guard = 0;
    logic rdy;
    exp_t e;
    while ((nxt < tab.size() || cur >= 0) && guard < 2000) begin
      guard++;
      hsel = 3'b000;
      if (nxt < tab.size()) begin
        hsel[d] = 1'b1;
        haddr   = tab[nxt].addr;
        htrans  = tab[nxt].trans;
        hwrite  = tab[nxt].wr;
        hsize   = tab[nxt].size;
      end else begin
        htrans = 2'b00;
        hwrite = 1'b0;
      end
      if (cur >= 0) begin
        hwdata = tab[cur].wdata;
        wstrb  = tab[cur].strb;
      end else begin
        hwdata = 32'h0;
        wstrb  = 4'hF;
      end
      @(negedge clk);
      rdy = hready[d];
      if (cur >= 0) begin
        check($sformatf("d%0d_i%0d_busy", d, cur), 32'(busy[d]), 32'd1);
        if (!rdy) begin
          low++;
          check($sformatf("d%0d_i%0d_wait_resp", d, cur), 32'(hresp[d]), 32'(sb[0].resp));
        end else if (sb.size() == 0) begin
          check($sformatf("d%0d_i%0d_scoreboard", d, cur), 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          check($sformatf("d%0d_i%0d_waits", d, e.idx), 32'(low), 32'(e.low));
          check($sformatf("d%0d_i%0d_resp", d, e.idx), 32'(hresp[d]), 32'(e.resp));
          if (e.chk_rd)
            check($sformatf("d%0d_i%0d_rdata", d, e.idx), hrdata[d], e.rd);
          $display("txn dut%0d item%0d %s addr=%h rdata=%h resp=%0d waits=%0d", d, e.idx,
                   tab[e.idx].wr ? "WR" : "RD", tab[e.idx].addr, hrdata[d], hresp[d], low);
          low = 0;
        end
      end else begin
        check($sformatf("d%0d_idle_busy", d), 32'(busy[d]), 32'd0);
        check($sformatf("d%0d_idle_ready", d), 32'(rdy), 32'd1);
      end
      step();
      if (rdy) begin
        cur = -1;
        if (nxt < tab.size()) begin
          if (tab[nxt].trans[1]) begin
            e.idx    = nxt;
            e.low    = (ERR_MODE && is_oor(tab[nxt].addr, tab[nxt].size)) ? 1 : ws_of(d);
            e.resp   = (ERR_MODE && is_oor(tab[nxt].addr, tab[nxt].size)) ? 2'b01 : 2'b00;
            e.chk_rd = !tab[nxt].wr && !(ERR_MODE && is_oor(tab[nxt].addr, tab[nxt].size));
            e.rd     = tab[nxt].exp;
            sb.push_back(e);
            cur = nxt;
          end
          nxt++;
        end
      end
    end
    if (guard >= 2000) check($sformatf("d%0d_table_timeout", d), 32'(guard), 32'd0);
    hsel   = 3'b000;
    htrans = 2'b00;
    sb.delete();
  endtask

  initial begin
    rst = 1'b1; hsel = 3'b000; haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'b010; hwdata = 32'h0; wstrb = 4'h0; req_start = 1'b0; req_ack = 1'b0;
    repeat (3) step();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("d%0d_rst_hrdata", d), hrdata[d], 32'h0);
      check($sformatf("d%0d_rst_hready", d), 32'(hready[d]), 32'd1);
      check($sformatf("d%0d_rst_hresp", d), 32'(hresp[d]), 32'd0);
      check($sformatf("d%0d_rst_busy", d), 32'(busy[d]), 32'd0);
      check($sformatf("d%0d_rst_dma_req", d), 32'(dma_req[d]), 32'd0);
    end
    step();
    rst = 1'b0;
    step();

    // trans, wr, addr, size, wdata, strb, expected read word
    add(TR_NONSEQ, 1, 32'h10,  SZ_WORD, 32'hDEADBEEF, 4'hF, 32'h0);
    add(TR_SEQ,    0, 32'h10,  SZ_WORD, 32'h0,        4'h0, 32'hDEADBEEF);
    add(TR_BUSY,   1, 32'h10,  SZ_WORD, 32'h0,        4'hF, 32'h0);
    add(TR_NONSEQ, 1, 32'h20,  SZ_WORD, 32'h11223344, 4'hF, 32'h0);
    add(TR_SEQ,    1, 32'h21,  SZ_BYTE, 32'h0000AB00, 4'h2, 32'h0);
    add(TR_SEQ,    0, 32'h20,  SZ_WORD, 32'h0,        4'h0, 32'h1122AB44);
    add(TR_SEQ,    0, 32'h21,  SZ_BYTE, 32'h0,        4'h0, 32'h1122AB44);
    add(TR_NONSEQ, 1, 32'h00,  SZ_WORD, 32'hCAFEF00D, 4'hF, 32'h0);
    add(TR_SEQ,    1, 32'h400, SZ_WORD, 32'h12345678, 4'hF, 32'h0);
    add(TR_SEQ,    0, 32'h00,  SZ_WORD, 32'h0,        4'h0, 32'hCAFEF00D);
    add(TR_SEQ,    0, 32'h400, SZ_WORD, 32'h0,        4'h0, 32'h0);
    add(TR_NONSEQ, 1, 32'h30,  SZ_WORD, 32'hA5A5A5A5, 4'hF, 32'h0);
    add(TR_SEQ,    1, 32'h32,  SZ_HALF, 32'hBEEF0000, 4'hC, 32'h0);
    add(TR_SEQ,    1, 32'h31,  SZ_HALF, 32'h0000FFFF, 4'h3, 32'h0);
    add(TR_SEQ,    0, 32'h30,  SZ_WORD, 32'h0,        4'h0, 32'hBEEFA5A5);
    add(TR_NONSEQ, 1, 32'h44,  SZ_WORD, 32'h01020304, 4'hF, 32'h0);
    add(TR_SEQ,    1, 32'h46,  SZ_WORD, 32'hFFFFFFFF, 4'hF, 32'h0);
    add(TR_SEQ,    0, 32'h44,  SZ_WORD, 32'h0,        4'h0, 32'h01020304);
    add(TR_NONSEQ, 1, 32'hA0 + 32'(DESC_DST),  SZ_WORD, 32'h10000000, 4'hF, 32'h0);
    add(TR_SEQ,    1, 32'hA0 + 32'(DESC_CTRL), SZ_WORD, 32'h00010020, 4'hF, 32'h0);
    add(TR_SEQ,    0, 32'hA0 + 32'(DESC_DST),  SZ_WORD, 32'h0,        4'h0, 32'h10000000);
    add(TR_SEQ,    0, 32'hA0 + 32'(DESC_CTRL), SZ_WORD, 32'h0,        4'h0, 32'h00010020);
    add(TR_IDLE,   0, 32'h10,  SZ_WORD, 32'h0,        4'h0, 32'h0);
    add(TR_NONSEQ, 0, 32'h10,  SZ_WORD, 32'h0,        4'h0, 32'hDEADBEEF);
    add(TR_NONSEQ, 1, 32'hFC,  SZ_WORD, 32'h89ABCDEF, 4'hF, 32'h0);
    add(TR_SEQ,    0, 32'hFC,  SZ_WORD, 32'h0,        4'h0, 32'h89ABCDEF);
    for (int d = 0; d < 3; d++) run_table(d);

    // Request handshake.
    req_start = 1'b1; step(); req_start = 1'b0;
    @(negedge clk); check("req_set", 32'(dma_req[0]), 32'd1);
    step(); step();
    @(negedge clk); check("req_held", 32'(dma_req[0]), 32'd1);
    req_ack = 1'b1; step(); req_ack = 1'b0;
    @(negedge clk); check("req_clear", 32'(dma_req[0]), 32'd0);
    req_ack = 1'b1; step(); req_ack = 1'b0;
    @(negedge clk); check("ack_while_low", 32'(dma_req[0]), 32'd0);
    req_start = 1'b1; req_ack = 1'b1; step(); req_start = 1'b0; req_ack = 1'b0;
    @(negedge clk); check("start_beats_ack", 32'(dma_req[0]), 32'd1);
    req_ack = 1'b1; step(); req_ack = 1'b0;
    @(negedge clk); check("req_clear2", 32'(dma_req[0]), 32'd0);
    step();

    // Reset asserted in a WAIT cycle of the 3-wait-state instance.
    tab.delete();
    add(TR_NONSEQ, 1, 32'h50, SZ_WORD, 32'h11111111, 4'hF, 32'h0);
    run_table(2);
    req_start = 1'b1; step(); req_start = 1'b0;
    hsel = 3'b100; haddr = 32'h50; htrans = TR_NONSEQ; hwrite = 1'b1; hsize = SZ_WORD;
    step();
    hsel = 3'b000; htrans = TR_IDLE; hwrite = 1'b0; hwdata = 32'h99999999; wstrb = 4'hF;
    @(negedge clk);
    check("rw_wait1_ready", 32'(hready[2]), 32'd0);
    check("rw_dma_req_up", 32'(dma_req[0]), 32'd1);
    step();
    rst = 1'b1;
    @(negedge clk); check("rw_wait2_ready", 32'(hready[2]), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rw_after_ready", 32'(hready[2]), 32'd1);
    check("rw_after_busy", 32'(busy[2]), 32'd0);
    check("rw_after_dma_req", 32'(dma_req[0]), 32'd0);
    check("rw_after_hresp", 32'(hresp[2]), 32'd0);
    check("rw_after_hrdata", hrdata[2], 32'h0);
    step();
    hwdata = 32'h0; wstrb = 4'h0;
    tab.delete();
    add(TR_NONSEQ, 0, 32'h50, SZ_WORD, 32'h0, 4'h0, 32'h11111111);
    run_table(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
